wb_mem_arbiter: RTL and testbench

- Two-master, one-slave Wishbone B3 arbiter that shares the external main-memory port (wb_*_mem_*_sim path) between the CPU-side interconnect master (m0) and the host loader/DMA master (m1).
- Grants are round-robin and held for a master's whole cycle, so registered-feedback bursts (cti/bte) stay atomic.
- A bus watchdog terminates stalled slave accesses with an error.
- Sits between the wb_intercon memory slave port and the top-level memory pins.

---
 rtl/wb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// wb_mem_arbiter
//
// Two-master / one-slave Wishbone B3 arbiter for the external main-memory port.
// Master 0 is the CPU-side interconnect, master 1 is the host loader / DMA.
// Ownership is round-robin and is held for the owner's whole cyc window, so
// registered-feedback bursts (cti/bte) are never interleaved. A bus watchdog
// terminates slave accesses that stall too long with an error to the owner.
//
// Handshake: a beat is offered when cyc & stb are high and completes in the
// cycle the slave raises exactly one of ack/err/rty; the master may only
// change adr/dat/sel/we/cti/bte after that completion (classic Wishbone
// valid = stb, ready = ack|err|rty).
//
// Parameters
//   AW             address width
//   DW             data width (byte selects are DW/8 wide)
//   TIMEOUT_CYCLES stall cycles before the watchdog fires; 0 disables it
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   m0_*_i / m1_*_i           master request signals (adr, dat, sel, we,
//                             cyc, stb, cti, bte)
//   m0_*_o / m1_*_o           read data and terminations (dat, ack, err, rty)
//   s_*_o                     shared slave request signals
//   s_dat_i, s_ack_i,
//   s_err_i, s_rty_i          slave response
//   grant_o                   one-hot current owner (00 = idle); this is the
//                             FSM state register itself
//   timeout_o                 sticky watchdog flag, cleared only by reset
// -----------------------------------------------------------------------------
module wb_mem_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,

    // master 0
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic [2:0]      m0_cti_i,
    input  logic [1:0]      m0_bte_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,

    // master 1
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic [2:0]      m1_cti_i,
    input  logic [1:0]      m1_bte_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,

    // slave
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic [2:0]      s_cti_o,
    output logic [1:0]      s_bte_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,

    // status
    output logic [1:0]      grant_o,
    output logic            timeout_o
);

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int            CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit            WD_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    // One-hot encoding doubles as the grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic            last_q,  last_d;   // master served most recently
    logic [CW-1:0]   wd_q,    wd_d;     // consecutive stall cycles
    logic            tmo_q,   tmo_d;

    // owner's request, selected from the registered grant only
    logic [AW-1:0]   own_adr;
    logic [DW-1:0]   own_dat;
    logic [DW/8-1:0] own_sel;
    logic            own_we;
    logic            own_cyc;
    logic            own_stb;
    logic [2:0]      own_cti;
    logic [1:0]      own_bte;

    logic            slv_term;
    logic            stall;
    logic            wd_fire;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;   // m0 wins the first tie after reset
            wd_q    <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            tmo_q   <= tmo_d;
        end
    end

    // -------------------------------------------------------------------------
    // Arbitration FSM
    // An owner keeps the bus for as long as its cyc stays high. When it drops
    // cyc the FSM hands over directly to a waiting master; the handover cycle
    // itself shows s_cyc_o low because the old owner's cyc is already low.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    last_d  = 1'b0;
                    state_d = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    last_d  = 1'b1;
                    state_d = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Request mux (driven by the registered grant, no added latency)
    // -------------------------------------------------------------------------
    always_comb begin
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        own_we  = 1'b0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_cti = '0;
        own_bte = '0;
        case (state_q)
            GNT0: begin
                own_adr = m0_adr_i;
                own_dat = m0_dat_i;
                own_sel = m0_sel_i;
                own_we  = m0_we_i;
                own_cyc = m0_cyc_i;
                own_stb = m0_stb_i;
                own_cti = m0_cti_i;
                own_bte = m0_bte_i;
            end
            GNT1: begin
                own_adr = m1_adr_i;
                own_dat = m1_dat_i;
                own_sel = m1_sel_i;
                own_we  = m1_we_i;
                own_cyc = m1_cyc_i;
                own_stb = m1_stb_i;
                own_cti = m1_cti_i;
                own_bte = m1_bte_i;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Watchdog
    // A slave termination in the terminal cycle suppresses the firing, so the
    // real response always wins over the synthetic error.
    // -------------------------------------------------------------------------
    assign slv_term = s_ack_i | s_err_i | s_rty_i;
    assign stall    = own_cyc & own_stb & ~slv_term;
    assign wd_fire  = WD_EN && stall && (wd_q == WD_LAST);

    always_comb begin
        wd_d  = wd_q + 1'b1;
        tmo_d = tmo_q | wd_fire;
        if (!WD_EN || !stall || wd_fire || (state_d != state_q)) begin
            wd_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Slave side: the firing cycle withdraws cyc/stb so the stalled slave
    // sees the access abandoned.
    // -------------------------------------------------------------------------
    assign s_adr_o = own_adr;
    assign s_dat_o = own_dat;
    assign s_sel_o = own_sel;
    assign s_we_o  = own_we;
    assign s_cyc_o = own_cyc & ~wd_fire;
    assign s_stb_o = own_stb & ~wd_fire;
    assign s_cti_o = own_cti;
    assign s_bte_o = own_bte;

    // -------------------------------------------------------------------------
    // Master side: only the owner sees responses; everyone else reads zero.
    // -------------------------------------------------------------------------
    always_comb begin
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        case (state_q)
            GNT0: begin
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | wd_fire;
                m0_rty_o = s_rty_i;
            end
            GNT1: begin
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | wd_fire;
                m1_rty_o = s_rty_i;
            end
            default: ;
        endcase
    end

    assign grant_o   = state_q;
    assign timeout_o = tmo_q;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_mem_arbiter
//
// Directed bench for wb_mem_arbiter with a short watchdog (8 cycles). Inputs
// change 1 ns after the rising edge and outputs are checked 1 ns later. Read
// data the bench hands to the slave port is pushed on exp_q and popped when
// the owning master sees its ack.
// -----------------------------------------------------------------------------
module tb_wb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;

    // ---------------- clock / reset ----------------
    logic wb_clk_i = 1'b0;
    logic wb_rst_i;
    always #5 wb_clk_i = ~wb_clk_i;

    logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [DW-1:0] m0_dat_i, m1_dat_i, s_dat_o, m0_dat_o, m1_dat_o, s_dat_i;
    logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
    logic          m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
    logic [2:0]    m0_cti_i, m1_cti_i, s_cti_o;
    logic [1:0]    m0_bte_i, m1_bte_i, s_bte_o;
    logic          m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic          s_we_o, s_cyc_o, s_stb_o;
    logic          s_ack_i, s_err_i, s_rty_i;
    logic [1:0]    grant_o;
    logic          timeout_o;

    wb_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
        .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i), .m0_sel_i (m0_sel_i),
        .m0_we_i  (m0_we_i),  .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i),
        .m0_cti_i (m0_cti_i), .m0_bte_i (m0_bte_i), .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o), .m0_rty_o (m0_rty_o),
        .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i), .m1_sel_i (m1_sel_i),
        .m1_we_i  (m1_we_i),  .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i),
        .m1_cti_i (m1_cti_i), .m1_bte_i (m1_bte_i), .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o), .m1_rty_o (m1_rty_o),
        .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),  .s_sel_o  (s_sel_o),
        .s_we_o   (s_we_o),   .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),
        .s_cti_o  (s_cti_o),  .s_bte_o  (s_bte_o),  .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),  .s_err_i  (s_err_i),  .s_rty_i  (s_rty_i),
        .grant_o  (grant_o),  .timeout_o (timeout_o)
    );

    // ---------------- scoreboard state ----------------
    int            n_assert = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rd;

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // m0 drives full byte selects, m1 drives 0x3 so the slave side shows
    // which master's signals are passing through.
    task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                           input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                           input logic [2:0] cti);
        if (m == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr;
            m0_dat_i = dat; m0_cti_i = cti; m0_bte_i = 2'b00; m0_sel_i = 4'hF;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr;
            m1_dat_i = dat; m1_cti_i = cti; m1_bte_i = 2'b00; m1_sel_i = 4'h3;
        end
    endtask

    task automatic drive_s(input logic ack, input logic err, input logic rty,
                           input logic [DW-1:0] dat);
        s_ack_i = ack; s_err_i = err; s_rty_i = rty; s_dat_i = dat;
    endtask

    task automatic chk_read(input string tag, input int m);
        logic [DW-1:0] e;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s observed=read expected=queued_data", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, (m == 0) ? m0_dat_o : m1_dat_o, e);
        end
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        drive_m(0, 0, 0, 0, '0, '0, 3'b000);
        drive_m(1, 0, 0, 0, '0, '0, 3'b000);
        drive_s(0, 0, 0, '0);
        tick();
        tick();
        wb_rst_i = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        wb_rst_i = 1'b1;
        drive_m(0, 0, 0, 0, '0, '0, 3'b000);
        drive_m(1, 0, 0, 0, '0, '0, 3'b000);
        drive_s(0, 0, 0, 32'h1234_5678);
        tick();
        tick();
        settle();
        // reset state (slave data is non-zero but nobody owns the bus)
        chk("rst_grant",   grant_o,   2'b00);
        chk("rst_s_cyc",   s_cyc_o,   1'b0);
        chk("rst_s_stb",   s_stb_o,   1'b0);
        chk("rst_s_adr",   s_adr_o,   '0);
        chk("rst_timeout", timeout_o, 1'b0);
        chk("rst_m0_dat",  m0_dat_o,  '0);
        chk("rst_m1_ack",  m1_ack_o,  1'b0);
        wb_rst_i = 1'b0;
        drive_s(0, 0, 0, '0);

        // ---- single m0 read, slave acks two cycles after strobe ----
        tick();
        drive_m(0, 1, 1, 0, 32'h100, '0, 3'b000);
        settle();
        chk("t1_stb_delayed", s_stb_o, 1'b0);
        chk("t1_grant_idle",  grant_o, 2'b00);
        tick();
        settle();
        chk("t1_stb",   s_stb_o, 1'b1);
        chk("t1_adr",   s_adr_o, 32'h100);
        chk("t1_grant", grant_o, 2'b01);
        chk("t1_noack", m0_ack_o, 1'b0);
        tick();
        settle();
        chk("t1_wait_ack", m0_ack_o, 1'b0);
        tick();
        exp_q.push_back(32'hDEAD_BEEF);
        drive_s(1, 0, 0, 32'hDEAD_BEEF);
        settle();
        chk("t1_ack", m0_ack_o, 1'b1);
        chk_read("t1_dat", 0);
        chk("t1_m1_dat", m1_dat_o, '0);
        chk("t1_m1_ack", m1_ack_o, 1'b0);
        tick();
        drive_m(0, 0, 0, 0, '0, '0, 3'b000);
        drive_s(0, 0, 0, '0);
        settle();
        chk("t1_grant_hold", grant_o, 2'b01);
        chk("t1_cyc_low",    s_cyc_o, 1'b0);
        tick();
        settle();
        chk("t1_grant_release", grant_o, 2'b00);

        // ---- tie after reset: m0 first, one idle cycle, then m1 ----
        do_reset();
        drive_m(0, 1, 1, 0, 32'h200, '0, 3'b000);
        drive_m(1, 1, 1, 1, 32'h300, 32'h1111_2222, 3'b000);
        settle();
        chk("t2_grant_idle", grant_o, 2'b00);
        tick();
        rd = 32'($urandom_range(32'h0, 32'hFFFF_FFFF));
        exp_q.push_back(rd);
        drive_s(1, 0, 0, rd);
        settle();
        chk("t2_grant_m0", grant_o, 2'b01);
        chk("t2_adr_m0",   s_adr_o, 32'h200);
        chk("t2_we_m0",    s_we_o,  1'b0);
        chk("t2_m0_ack",   m0_ack_o, 1'b1);
        chk_read("t2_m0_dat", 0);
        chk("t2_m1_ack_blocked", m1_ack_o, 1'b0);
        tick();
        drive_m(0, 0, 0, 0, '0, '0, 3'b000);
        drive_s(0, 0, 0, '0);
        settle();
        chk("t2_gap_cyc", s_cyc_o, 1'b0);
        tick();
        drive_s(1, 0, 0, '0);
        settle();
        chk("t2_grant_m1", grant_o, 2'b10);
        chk("t2_adr_m1",   s_adr_o, 32'h300);
        chk("t2_we_m1",    s_we_o,  1'b1);
        chk("t2_wdat_m1",  s_dat_o, 32'h1111_2222);
        chk("t2_sel_m1",   s_sel_o, 4'h3);
        chk("t2_m1_ack",   m1_ack_o, 1'b1);
        chk("t2_m0_ack_off", m0_ack_o, 1'b0);
        tick();
        drive_m(1, 0, 0, 0, '0, '0, 3'b000);
        drive_s(0, 0, 0, '0);
        tick();
        settle();
        chk("t2_idle_again", grant_o, 2'b00);
        // second tie: pointer now points at m1, so m0 wins again
        drive_m(0, 1, 1, 0, 32'h204, '0, 3'b000);
        drive_m(1, 1, 1, 0, 32'h304, '0, 3'b000);
        tick();
        settle();
        chk("t2_retie_m0", grant_o, 2'b01);
        drive_m(0, 0, 0, 0, '0, '0, 3'b000);
        drive_m(1, 0, 0, 0, '0, '0, 3'b000);
        tick();
        tick();
        settle();
        chk("t2_retie_idle", grant_o, 2'b00);

        // ---- burst atomicity: m1 requests during m0's 4-beat burst ----
        drive_m(0, 1, 1, 0, 32'h400, '0, 3'b010);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive_m(0, 1, 1, 0, 32'h400 + 32'(4 * i), '0, (i == 3) ? 3'b111 : 3'b010);
            if (i == 0) drive_m(1, 1, 1, 1, 32'h900, 32'h5555_AAAA, 3'b000);
            rd = 32'($urandom_range(32'h0, 32'hFFFF_FFFF));
            exp_q.push_back(rd);
            drive_s(1, 0, 0, rd);
            settle();
            chk("t3_grant",  grant_o, 2'b01);
            chk("t3_adr",    s_adr_o, 32'h400 + 32'(4 * i));
            chk("t3_cti",    s_cti_o, (i == 3) ? 3'b111 : 3'b010);
            chk("t3_we",     s_we_o,  1'b0);
            chk("t3_m0_ack", m0_ack_o, 1'b1);
            chk_read("t3_m0_dat", 0);
            chk("t3_m1_ack", m1_ack_o, 1'b0);
            tick();
        end
        drive_m(0, 0, 0, 0, '0, '0, 3'b000);
        drive_s(0, 0, 0, '0);
        settle();
        chk("t3_gap_cyc",   s_cyc_o, 1'b0);
        chk("t3_gap_m1ack", m1_ack_o, 1'b0);
        tick();
        settle();
        chk("t3_m1_grant", grant_o, 2'b10);
        chk("t3_m1_adr",   s_adr_o, 32'h900);
        drive_m(1, 0, 0, 0, '0, '0, 3'b000);
        tick();
        tick();

        // ---- watchdog boundary: ack arrives on the terminal stall cycle ----
        drive_m(1, 1, 1, 1, 32'h500, 32'hCAFE_0001, 3'b000);
        tick();
        for (int k = 1; k < TMO; k++) begin
            settle();
            chk("t4_stall_err", m1_err_o, 1'b0);
            chk("t4_stall_stb", s_stb_o,  1'b1);
            tick();
        end
        drive_s(1, 0, 0, '0);
        settle();
        chk("t4_term_ack", m1_ack_o,  1'b1);
        chk("t4_term_err", m1_err_o,  1'b0);
        chk("t4_term_stb", s_stb_o,   1'b1);
        tick();
        drive_m(1, 0, 0, 0, '0, '0, 3'b000);
        drive_s(0, 0, 0, '0);
        tick();
        settle();
        chk("t4_no_timeout", timeout_o, 1'b0);
        chk("t4_idle",       grant_o,   2'b00);

        // ---- watchdog fires: slave never answers m1's write ----
        drive_m(1, 1, 1, 1, 32'h504, 32'hCAFE_0002, 3'b000);
        tick();
        for (int k = 1; k < TMO; k++) begin
            settle();
            chk("t5_stall_err", m1_err_o, 1'b0);
            tick();
        end
        settle();
        chk("t5_fire_err",   m1_err_o,  1'b1);
        chk("t5_fire_ack",   m1_ack_o,  1'b0);
        chk("t5_fire_stb",   s_stb_o,   1'b0);
        chk("t5_fire_cyc",   s_cyc_o,   1'b0);
        chk("t5_flag_late",  timeout_o, 1'b0);
        tick();
        settle();
        chk("t5_flag_set",   timeout_o, 1'b1);
        chk("t5_err_pulse",  m1_err_o,  1'b0);
        chk("t5_grant_kept", grant_o,   2'b10);
        chk("t5_stb_back",   s_stb_o,   1'b1);
        drive_m(1, 0, 0, 0, '0, '0, 3'b000);
        tick();
        tick();
        settle();
        chk("t5_flag_sticky", timeout_o, 1'b1);
        chk("t5_idle",        grant_o,   2'b00);

        // ---- slave err / rty pass through to the owner ----
        drive_m(0, 1, 1, 0, 32'h700, '0, 3'b000);
        tick();
        drive_s(0, 1, 0, '0);
        settle();
        chk("t6_m0_err",  m0_err_o, 1'b1);
        chk("t6_m1_err",  m1_err_o, 1'b0);
        chk("t6_cyc",     s_cyc_o,  1'b1);
        drive_s(0, 0, 1, '0);
        settle();
        chk("t6_m0_rty",  m0_rty_o, 1'b1);
        chk("t6_m0_err0", m0_err_o, 1'b0);
        chk("t6_m1_rty",  m1_rty_o, 1'b0);
        drive_s(0, 0, 0, '0);
        drive_m(0, 0, 0, 0, '0, '0, 3'b000);
        tick();
        tick();

        // ---- reset during beat 2 of an m1 burst ----
        drive_m(1, 1, 1, 0, 32'h600, '0, 3'b010);
        tick();
        rd = 32'h0BAD_F00D;
        exp_q.push_back(rd);
        drive_s(1, 0, 0, rd);
        settle();
        chk("t7_beat1_ack", m1_ack_o, 1'b1);
        chk_read("t7_beat1_dat", 1);
        tick();
        drive_m(1, 1, 1, 0, 32'h604, '0, 3'b010);
        drive_s(0, 0, 0, '0);
        wb_rst_i = 1'b1;
        settle();
        chk("t7_beat2_grant", grant_o, 2'b10);
        tick();
        settle();
        chk("t7_rst_grant",  grant_o,   2'b00);
        chk("t7_rst_cyc",    s_cyc_o,   1'b0);
        chk("t7_rst_m1_ack", m1_ack_o,  1'b0);
        chk("t7_rst_m1_err", m1_err_o,  1'b0);
        chk("t7_rst_m1_rty", m1_rty_o,  1'b0);
        chk("t7_rst_tmo",    timeout_o, 1'b0);
        wb_rst_i = 1'b0;
        drive_m(0, 1, 1, 0, 32'h800, '0, 3'b000);
        tick();
        settle();
        chk("t7_m0_first", grant_o, 2'b01);
        chk("t7_m0_adr",   s_adr_o, 32'h800);
        drive_m(0, 0, 0, 0, '0, '0, 3'b000);
        drive_m(1, 0, 0, 0, '0, '0, 3'b000);
        tick();
        tick();

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
